// File: rtl/sin_cos_gen.sv
// sin_cos_gen: sine/cosine generator built on the coupled-form recurrence
//   cos' = cos - (sin >>> s), sin' = sin + (cos >>> s)
// with a step angle of 2^-s rad. The oscillator is re-seeded after L(s)
// advances so amplitude and phase drift never accumulate across periods.
//
// Handshake: start and stop are single-cycle strobes sampled on the rising
// edge; there is no ready, and a start is either accepted on the next edge or
// rejected with a start_err pulse. valid is high exactly while the FSM is in
// RUN; sin/cos carry a new sample on every edge where en is high, and they
// hold while en is low.
module sin_cos_gen #(
    parameter int WIDTH = 32,
    parameter int S_MIN = 2,
    parameter int S_MAX = 10,
    parameter int SW    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    en,
    input  logic [SW-1:0]           shift,
    input  logic [WIDTH-1:0]        amp,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos,
    output logic                    valid,
    output logic                    cycle_done,
    output logic                    start_err
);

    // Period length in advances for shift s: floor(2^s * 6.28) + 1.
    // Only ever evaluated with constant arguments during elaboration.
    function automatic longint l_of(input int s);
        return ((longint'(1) << s) * 628) / 100 + 1;
    endfunction

    localparam int CW = $clog2(l_of(S_MAX)) + 1;

    // Default amplitude and clamp limit keep |sin|,|cos| clear of wrap-around.
    localparam logic [WIDTH-1:0] AMP_DEF = {3'b001, {(WIDTH-3){1'b0}}};
    localparam logic [WIDTH-1:0] AMP_MAX = {2'b00, {(WIDTH-2){1'b1}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] sin_n, cos_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [SW-1:0]           s_reg, s_n;
    logic [WIDTH-1:0]        amp_reg, amp_n;
    logic                    valid_n, cycle_done_n, start_err_n;
    logic                    shift_ok;
    logic [WIDTH-1:0]        amp_sel;

    // Elaboration-time period table, one entry per possible shift code;
    // out-of-range codes can never be latched, so their entries are zero.
    logic [CW-1:0] l_tab [2**SW];

    for (genvar g = 0; g < 2**SW; g++) begin : g_ltab
        if (g >= S_MIN && g <= S_MAX) begin : g_on
            assign l_tab[g] = CW'(l_of(g));
        end else begin : g_off
            assign l_tab[g] = '0;
        end
    end

    // Start qualification and amplitude selection (default / clamp).
    always_comb begin
        shift_ok = (shift >= SW'(S_MIN)) && (shift <= SW'(S_MAX));
        amp_sel  = amp;
        if (amp == '0) begin
            amp_sel = AMP_DEF;
        end else if (amp > AMP_MAX) begin
            amp_sel = AMP_MAX;
        end
    end

    // Next-state and next-output logic; stop beats start, start beats advance.
    always_comb begin
        state_n      = state;
        sin_n        = sin;
        cos_n        = cos;
        cnt_n        = cnt;
        s_n          = s_reg;
        amp_n        = amp_reg;
        valid_n      = valid;
        cycle_done_n = 1'b0;
        start_err_n  = start && !shift_ok;

        if (stop) begin
            state_n = IDLE;
            sin_n   = '0;
            cos_n   = '0;
            cnt_n   = '0;
            valid_n = 1'b0;
        end else if (start && shift_ok) begin
            // A restart abandons the current period without a cycle_done.
            state_n = RUN;
            s_n     = shift;
            amp_n   = amp_sel;
            sin_n   = '0;
            cos_n   = amp_sel;
            cnt_n   = l_tab[shift];
            valid_n = 1'b1;
        end else if (state == RUN && en) begin
            if (cnt > CW'(1)) begin
                cos_n = cos - (sin >>> s_reg);
                sin_n = sin + (cos >>> s_reg);
                cnt_n = cnt - CW'(1);
            end else begin
                // Last advance of the period: re-seed instead of stepping.
                sin_n        = '0;
                cos_n        = WIDTH'(amp_reg);
                cnt_n        = l_tab[s_reg];
                cycle_done_n = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sin        <= '0;
            cos        <= '0;
            cnt        <= '0;
            s_reg      <= SW'(S_MIN);
            amp_reg    <= AMP_DEF;
            valid      <= 1'b0;
            cycle_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            state      <= state_n;
            sin        <= sin_n;
            cos        <= cos_n;
            cnt        <= cnt_n;
            s_reg      <= s_n;
            amp_reg    <= amp_n;
            valid      <= valid_n;
            cycle_done <= cycle_done_n;
            start_err  <= start_err_n;
        end
    end

endmodule

// File: tb/tb_sin_cos_gen.sv
// tb_sin_cos_gen: directed vector table plus hand-written multi-cycle
// sequences (full periods, en stall, reset mid-period) for sin_cos_gen.
module tb_sin_cos_gen;

    localparam int WIDTH = 16;
    localparam int S_MIN = 2;
    localparam int S_MAX = 10;
    localparam int SW    = 4;
    localparam int NV    = 25;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    stop;
    logic                    en;
    logic [SW-1:0]           shift;
    logic [WIDTH-1:0]        amp;
    logic signed [WIDTH-1:0] sin;
    logic signed [WIDTH-1:0] cos;
    logic                    valid;
    logic                    cycle_done;
    logic                    start_err;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries: {cycle_done, sin, cos}
    logic [2*WIDTH:0] exp_q[$];

    // Reference state of the oscillator
    logic signed [WIDTH-1:0] m_sin, m_cos;
    int                      m_cnt, m_s, m_amp;

    typedef struct packed {
        logic                    rst;
        logic                    st;
        logic                    sp;
        logic                    e;
        logic [SW-1:0]           sh;
        logic [WIDTH-1:0]        am;
        logic signed [WIDTH-1:0] es;
        logic signed [WIDTH-1:0] ec;
        logic                    ev;
        logic                    ecd;
        logic                    eerr;
    } vec_t;

    vec_t vecs [NV];

    sin_cos_gen #(
        .WIDTH(WIDTH),
        .S_MIN(S_MIN),
        .S_MAX(S_MAX),
        .SW   (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .shift     (shift),
        .amp       (amp),
        .sin       (sin),
        .cos       (cos),
        .valid     (valid),
        .cycle_done(cycle_done),
        .start_err (start_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then wait past the next rising edge.
    task automatic apply(input logic r, input logic st, input logic sp, input logic e,
                         input logic [SW-1:0] sh, input logic [WIDTH-1:0] am);
        @(negedge clk);
        reset = r;
        start = st;
        stop  = sp;
        en    = e;
        shift = sh;
        amp   = am;
        @(posedge clk);
        #1;
    endtask

    function automatic int l_len(input int s);
        return ((1 << s) * 628) / 100 + 1;
    endfunction

    task automatic model_load(input int s, input int a);
        m_s   = s;
        m_amp = a;
        m_sin = '0;
        m_cos = WIDTH'(a);
        m_cnt = l_len(s);
    endtask

    // One enabled advance of the reference; returns whether the period wrapped.
    task automatic model_step(output logic cd);
        logic signed [WIDTH-1:0] os, oc;
        os = m_sin;
        oc = m_cos;
        cd = 1'b0;
        if (m_cnt > 1) begin
            m_cos = oc - (os >>> m_s);
            m_sin = os + (oc >>> m_s);
            m_cnt--;
        end else begin
            m_sin = '0;
            m_cos = WIDTH'(m_amp);
            m_cnt = l_len(m_s);
            cd    = 1'b1;
        end
    endtask

    task automatic score(input string name);
        logic [2*WIDTH:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".sin"}, longint'(sin), longint'($signed(e[2*WIDTH-1:WIDTH])));
            check({name, ".cos"}, longint'(cos), longint'($signed(e[WIDTH-1:0])));
            check({name, ".cd"}, longint'(cycle_done), longint'(e[2*WIDTH]));
        end
    endtask

    initial begin
        logic cd;
        int   pulses;
        int   first_cd;
        logic e;

        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        en    = 1'b0;
        shift = '0;
        amp   = '0;

        // rst st sp en sh amp  -> sin cos valid cd err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd11, 16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd8192,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd512,  16'sd8192,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd1024, 16'sd8160,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  16'd0,     16'sd1024, 16'sd8160,  1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd1534, 16'sd8096,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  16'd20000, 16'sd0,    16'sd16383, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd20000, 16'sd1023, 16'sd16383, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  16'd5,     16'sd2046, 16'sd16320, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  16'd100,   16'sd0,    16'sd100,   1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  16'd100,   16'sd25,   16'sd100,   1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 16'd0,     16'sd0,    16'sd8192,  1'b1, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd10, 16'd0,     16'sd8,    16'sd8192,  1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 16'd0,     16'sd0,    16'sd0,     1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].e, vecs[i].sh, vecs[i].am);
            check($sformatf("vec%0d.sin", i), longint'(sin), longint'(vecs[i].es));
            check($sformatf("vec%0d.cos", i), longint'(cos), longint'(vecs[i].ec));
            check($sformatf("vec%0d.valid", i), longint'(valid), longint'(vecs[i].ev));
            check($sformatf("vec%0d.cycle_done", i), longint'(cycle_done), longint'(vecs[i].ecd));
            check($sformatf("vec%0d.start_err", i), longint'(start_err), longint'(vecs[i].eerr));
        end

        // Three full periods at shift 4, default amplitude.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'd0);
        model_load(4, 8192);
        check("per.first_cos", longint'(cos), 64'sd8192);
        pulses = 0;
        for (int i = 1; i <= 3 * 101; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'd0);
            model_step(cd);
            exp_q.push_back({cd, m_sin, m_cos});
            score($sformatf("per%0d", i));
            if (cycle_done) pulses++;
            if (i % 101 == 0) begin
                check($sformatf("per%0d.wrap_sin", i), longint'(sin), 64'sd0);
                check($sformatf("per%0d.wrap_cos", i), longint'(cos), 64'sd8192);
                check($sformatf("per%0d.wrap_cd", i), longint'(cycle_done), 64'sd1);
            end
        end
        check("per.pulses", longint'(pulses), 64'sd3);

        // en held low for 5 clocks mid-period delays the wrap by 5 clocks.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'd0);
        model_load(4, 8192);
        first_cd = 0;
        for (int k = 1; k <= 120; k++) begin
            e = !(k >= 51 && k <= 55);
            apply(1'b1, 1'b0, 1'b0, e, 4'd4, 16'd0);
            cd = 1'b0;
            if (e) model_step(cd);
            exp_q.push_back({cd, m_sin, m_cos});
            score($sformatf("stall%0d", k));
            check($sformatf("stall%0d.valid", k), longint'(valid), 64'sd1);
            if (cycle_done && first_cd == 0) first_cd = k;
        end
        check("stall.wrap_clock", longint'(first_cd), 64'sd106);

        // Reset on the clock that would end the period: no cycle_done.
        apply(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'd0);
        model_load(4, 8192);
        for (int k = 1; k <= 100; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'd0);
            model_step(cd);
        end
        check("rstmid.pre_sin", longint'(sin), longint'(m_sin));
        check("rstmid.pre_cos", longint'(cos), longint'(m_cos));
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'd0);
        check("rstmid.cd", longint'(cycle_done), 64'sd0);
        check("rstmid.valid", longint'(valid), 64'sd0);
        check("rstmid.sin", longint'(sin), 64'sd0);
        check("rstmid.cos", longint'(cos), 64'sd0);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 16'd0);
        check("rstmid.idle_valid", longint'(valid), 64'sd0);
        check("rstmid.idle_cos", longint'(cos), 64'sd0);

        check("scoreboard.drained", longint'(exp_q.size()), 64'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
